// File: rtl/puzzle_pkg.sv
// puzzle_pkg: constants shared by the 3x3 sliding-puzzle move player and any
// future board checker.
//   - Direction codes describe the motion of the blank tile.
//   - Solution word layout: [44:40] move count, move i at [39-2i:38-2i].
//   - Board layout: cell k at [4k+3:4k], k = row*3 + col, row 0 at top.
package puzzle_pkg;

    localparam int MAX_MOVES  = 20;
    localparam int CNT_W      = 5;
    localparam int TILE_W     = 4;
    localparam int NUM_CELLS  = 9;
    localparam int POS_W      = 4;
    localparam int DIR_W      = 2;

    localparam logic [TILE_W-1:0] BLANK_TILE = 4'd5;

    // Solution-word field offsets
    localparam int WORD_W     = CNT_W + DIR_W * MAX_MOVES;  // 45
    localparam int CNT_LSB    = DIR_W * MAX_MOVES;          // 40
    localparam int CNT_MSB    = WORD_W - 1;                 // 44
    localparam int MOVE0_MSB  = CNT_LSB - 1;                // 39

    localparam int BOARD_W    = NUM_CELLS * TILE_W;         // 36

    // Blank-motion directions
    localparam logic [DIR_W-1:0] DIR_UP    = 2'b11;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b00;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    // Extract move field idx from a solution word. Out-of-range indices
    // return 0; the player never asks for them.
    function automatic logic [DIR_W-1:0] move_field(input logic [WORD_W-1:0] word,
                                                    input logic [CNT_W-1:0]  idx);
        logic [WORD_W-1:0] shifted;
        shifted = '0;
        if (int'(idx) >= MAX_MOVES) begin
            return '0;
        end
        shifted = word >> (MOVE0_MSB - 1 - 2 * int'(idx));
        return shifted[DIR_W-1:0];
    endfunction

endpackage

// File: rtl/puzzle_move_target.sv
// puzzle_move_target: combinational neighbour lookup on a 3x3 board.
// Ports:
//   blank_pos  in  4  current blank cell index (0..8)
//   dir        in  2  requested blank motion
//   target     out 4  cell the blank would move to (blank_pos when illegal)
//   legal      out 1  move stays on the board
module puzzle_move_target
    import puzzle_pkg::*;
(
    input  logic [POS_W-1:0] blank_pos,
    input  logic [DIR_W-1:0] dir,
    output logic [POS_W-1:0] target,
    output logic             legal
);

    logic [1:0] row;
    logic [1:0] col;
    logic       pos_valid;

    // Row/column by table: avoids a divider for a 9-entry domain.
    always_comb begin
        row       = 2'd0;
        col       = 2'd0;
        pos_valid = 1'b1;
        case (blank_pos)
            4'd0: begin row = 2'd0; col = 2'd0; end
            4'd1: begin row = 2'd0; col = 2'd1; end
            4'd2: begin row = 2'd0; col = 2'd2; end
            4'd3: begin row = 2'd1; col = 2'd0; end
            4'd4: begin row = 2'd1; col = 2'd1; end
            4'd5: begin row = 2'd1; col = 2'd2; end
            4'd6: begin row = 2'd2; col = 2'd0; end
            4'd7: begin row = 2'd2; col = 2'd1; end
            4'd8: begin row = 2'd2; col = 2'd2; end
            default: pos_valid = 1'b0;
        endcase
    end

    always_comb begin
        target = blank_pos;
        legal  = 1'b0;
        if (pos_valid) begin
            case (dir)
                DIR_UP: begin
                    if (row != 2'd0) begin
                        legal  = 1'b1;
                        target = blank_pos - 4'd3;
                    end
                end
                DIR_DOWN: begin
                    if (row != 2'd2) begin
                        legal  = 1'b1;
                        target = blank_pos + 4'd3;
                    end
                end
                DIR_LEFT: begin
                    if (col != 2'd0) begin
                        legal  = 1'b1;
                        target = blank_pos - 4'd1;
                    end
                end
                default: begin  // DIR_RIGHT
                    if (col != 2'd2) begin
                        legal  = 1'b1;
                        target = blank_pos + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/puzzle_move_player.sv
// puzzle_move_player: replays a 45-bit solution word on a registered 3x3 board.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start         load sol_word/board_in (ignored while replaying)
//   sol_word      [44:40] move count, move i at [39-2i:38-2i]
//   board_in      initial board, cell k at [4k+3:4k]
//   step_en       apply one move this cycle
//   busy/done/err replay in progress / finished / bad word or illegal move
//   move_strobe   one-cycle pulse per applied move
//   move_dir      direction of last applied move
//   move_idx      moves applied so far
//   board_out     current board
//   blank_pos     current blank cell index
module puzzle_move_player
    import puzzle_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WORD_W-1:0]  sol_word,
    input  logic [BOARD_W-1:0] board_in,
    input  logic               step_en,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               move_strobe,
    output logic [DIR_W-1:0]   move_dir,
    output logic [CNT_W-1:0]   move_idx,
    output logic [BOARD_W-1:0] board_out,
    output logic [POS_W-1:0]   blank_pos
);

    state_e state_reg, state_next;

    logic [WORD_W-1:0]                   word_reg,   word_next;
    logic [NUM_CELLS-1:0][TILE_W-1:0]    board_reg,  board_next;
    logic [POS_W-1:0]                    blank_reg,  blank_next;
    logic [CNT_W-1:0]                    idx_reg,    idx_next;
    logic [DIR_W-1:0]                    dir_reg,    dir_next;
    logic                                strobe_reg, strobe_next;

    logic [NUM_CELLS-1:0][TILE_W-1:0]    board_in_cells;
    logic [NUM_CELLS-1:0]                is_blank;
    logic                                blank_found;
    logic [POS_W-1:0]                    blank_found_pos;
    logic [CNT_W-1:0]                    count_in;
    logic [CNT_W-1:0]                    count_reg;
    logic [DIR_W-1:0]                    cur_dir;
    logic [POS_W-1:0]                    target;
    logic                                legal;

    assign board_in_cells = board_in;
    assign count_in       = sol_word[CNT_MSB:CNT_LSB];
    assign count_reg      = word_reg[CNT_MSB:CNT_LSB];
    assign cur_dir        = move_field(word_reg, idx_reg);

    generate
        for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_blank_scan
            assign is_blank[gi] = (board_in_cells[gi] == BLANK_TILE);
        end
    endgenerate

    // Lowest-index blank wins if the incoming board holds several.
    always_comb begin
        blank_found     = 1'b0;
        blank_found_pos = '0;
        for (int k = NUM_CELLS - 1; k >= 0; k--) begin
            if (is_blank[k]) begin
                blank_found     = 1'b1;
                blank_found_pos = POS_W'(k);
            end
        end
    end

    puzzle_move_target u_target (
        .blank_pos (blank_reg),
        .dir       (cur_dir),
        .target    (target),
        .legal     (legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            word_reg   <= '0;
            board_reg  <= '0;
            blank_reg  <= '0;
            idx_reg    <= '0;
            dir_reg    <= '0;
            strobe_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            word_reg   <= word_next;
            board_reg  <= board_next;
            blank_reg  <= blank_next;
            idx_reg    <= idx_next;
            dir_reg    <= dir_next;
            strobe_reg <= strobe_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        word_next   = word_reg;
        board_next  = board_reg;
        blank_next  = blank_reg;
        idx_next    = idx_reg;
        dir_next    = dir_reg;
        strobe_next = 1'b0;

        if (start && (state_reg != RUN)) begin
            word_next  = sol_word;
            board_next = board_in_cells;
            idx_next   = '0;
            blank_next = blank_found_pos;
            if (!blank_found || (count_in > CNT_W'(MAX_MOVES))) begin
                state_next = ERR;
            end else if (count_in == '0) begin
                state_next = DONE;
            end else begin
                state_next = RUN;
            end
        end else if ((state_reg == RUN) && step_en) begin
            if (legal) begin
                board_next[blank_reg] = board_reg[target];
                board_next[target]    = board_reg[blank_reg];
                blank_next            = target;
                idx_next              = idx_reg + 5'd1;
                dir_next              = cur_dir;
                strobe_next           = 1'b1;
                if ((idx_reg + 5'd1) == count_reg) begin
                    state_next = DONE;
                end
            end else begin
                // Board, blank and index stay frozen at the last good move.
                state_next = ERR;
            end
        end
    end

    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign err         = (state_reg == ERR);
    assign move_strobe = strobe_reg;
    assign move_dir    = dir_reg;
    assign move_idx    = idx_reg;
    assign board_out   = board_reg;
    assign blank_pos   = blank_reg;

endmodule

// File: tb/tb_puzzle_move_player.sv
module tb_puzzle_move_player;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [44:0] sol_word = '0;
    logic [35:0] board_in = '0;
    logic        step_en = 1'b0;
    logic        busy, done, err, move_strobe;
    logic [1:0]  move_dir;
    logic [4:0]  move_idx;
    logic [35:0] board_out;
    logic [3:0]  blank_pos;

    always #5 clk = ~clk;

    puzzle_move_player dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sol_word    (sol_word),
        .board_in    (board_in),
        .step_en     (step_en),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .move_strobe (move_strobe),
        .move_dir    (move_dir),
        .move_idx    (move_idx),
        .board_out   (board_out),
        .blank_pos   (blank_pos)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // m_phase: 0 idle, 1 replaying, 2 finished, 3 error
    int          m_phase;
    int          m_board[9];
    int          m_blank;
    int          m_idx;
    int          m_dir;
    bit          m_strobe;
    logic [44:0] m_word;
    int          m_cnt;

    function automatic bit move_ok(input int pos, input int d, output int t);
        int r = pos / 3;
        int c = pos % 3;
        t = pos;
        case (d)
            3: if (r > 0) begin t = pos - 3; return 1'b1; end
            0: if (r < 2) begin t = pos + 3; return 1'b1; end
            2: if (c > 0) begin t = pos - 1; return 1'b1; end
            default: if (c < 2) begin t = pos + 1; return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    function automatic logic [35:0] pack_cells(input int c[9]);
        logic [35:0] r = '0;
        for (int k = 0; k < 9; k++) r[4*k +: 4] = 4'(c[k]);
        return r;
    endfunction

    function automatic logic [44:0] make_word(input int cnt, input int mv[20]);
        logic [44:0] w = '0;
        w[44:40] = 5'(cnt);
        for (int i = 0; i < 20; i++) w[39-2*i -: 2] = 2'(mv[i]);
        return w;
    endfunction

    task automatic model_step(input bit r, input bit s, input logic [44:0] w,
                              input logic [35:0] b, input bit se);
        int t, mv, tmp;
        if (r) begin
            m_phase = 0; m_blank = 0; m_idx = 0; m_dir = 0; m_strobe = 0;
            m_word = '0; m_cnt = 0;
            for (int k = 0; k < 9; k++) m_board[k] = 0;
            return;
        end
        m_strobe = 0;
        if (s && m_phase != 1) begin
            m_word = w;
            m_cnt  = int'(w[44:40]);
            m_idx  = 0;
            m_blank = -1;
            for (int k = 0; k < 9; k++) begin
                m_board[k] = int'(b[4*k +: 4]);
                if (m_board[k] == 5 && m_blank < 0) m_blank = k;
            end
            if (m_blank < 0) begin
                m_blank = 0;
                m_phase = 3;
            end else if (m_cnt > 20) m_phase = 3;
            else if (m_cnt == 0)     m_phase = 2;
            else                     m_phase = 1;
        end else if (m_phase == 1 && se) begin
            mv = int'((m_word >> (38 - 2*m_idx)) & 45'd3);
            if (move_ok(m_blank, mv, t)) begin
                tmp = m_board[t]; m_board[t] = m_board[m_blank]; m_board[m_blank] = tmp;
                m_blank = t;
                m_idx++;
                m_dir = mv;
                m_strobe = 1;
                if (m_idx == m_cnt) m_phase = 2;
            end else begin
                m_phase = 3;
            end
        end
    endtask

    task automatic compare_all();
        check_value("busy",        busy,        m_phase == 1);
        check_value("done",        done,        m_phase == 2);
        check_value("err",         err,         m_phase == 3);
        check_value("move_strobe", move_strobe, m_strobe);
        check_value("move_dir",    move_dir,    m_dir);
        check_value("move_idx",    move_idx,    m_idx);
        check_value("board_out",   board_out,   pack_cells(m_board));
        check_value("blank_pos",   blank_pos,   m_blank);
    endtask

    task automatic cycle(input bit r, input bit s, input logic [44:0] w,
                         input logic [35:0] b, input bit se);
        @(negedge clk);
        rst = r; start = s; sol_word = w; board_in = b; step_en = se;
        @(posedge clk);
        model_step(r, s, w, b, se);
        #1;
        compare_all();
    endtask

    int txn = 0;

    // mode 0: step_en held, 1: every 3rd cycle, 2: random.
    // poke_start: issue a start with a different word while replaying.
    // rst_after: assert reset after this many replay cycles (-1 never).
    task automatic run_word(input logic [44:0] w, input logic [35:0] b, input int mode,
                            input bit poke_start, input int rst_after);
        bit se;
        bit s;
        bit rr;
        cycle(0, 1, w, b, 0);
        for (int i = 0; i < 150 && m_phase == 1; i++) begin
            case (mode)
                0:       se = 1'b1;
                1:       se = (i % 3) == 2;
                default: se = ($urandom_range(0, 9) < 6);
            endcase
            s  = poke_start && (i == 1);
            rr = (i == rst_after);
            cycle(rr, s, {$urandom, $urandom}, {$urandom, $urandom}, se);
        end
        if (m_phase == 1) check_value("budget_busy", busy, 0);
        txn++;
        $display("txn %0d: count=%0d mode=%0d -> busy=%0b done=%0b err=%0b idx=%0d blank=%0d",
                 txn, w[44:40], mode, busy, done, err, move_idx, blank_pos);
    endtask

    int cells[9];
    int mv[20];
    logic [44:0] w;
    logic [35:0] b;
    int final_cells[9];

    initial begin
        // reset
        cycle(1, 0, '0, '0, 0);
        cycle(1, 0, '0, '0, 0);
        cycle(0, 0, '0, '0, 1);

        // canonical 4-move word
        for (int k = 0; k < 9; k++) cells[k] = k + 1;
        for (int i = 0; i < 20; i++) mv[i] = 0;
        mv[0] = 3; mv[1] = 2; mv[2] = 0; mv[3] = 1;
        w = make_word(4, mv);
        b = pack_cells(cells);
        run_word(w, b, 0, 0, -1);
        final_cells = '{4, 1, 3, 2, 5, 6, 7, 8, 9};
        check_value("canon_board", board_out, pack_cells(final_cells));
        check_value("canon_done",  done, 1);
        check_value("canon_err",   err, 0);
        check_value("canon_blank", blank_pos, 4);

        // illegal first move (blank at 0, up)
        cells = '{5, 1, 2, 3, 4, 6, 7, 8, 9};
        for (int i = 0; i < 20; i++) mv[i] = 3;
        run_word(make_word(3, mv), pack_cells(cells), 0, 0, -1);
        check_value("illegal_err",   err, 1);
        check_value("illegal_board", board_out, pack_cells(cells));
        check_value("illegal_idx",   move_idx, 0);

        // malformed count 21
        run_word(make_word(21, mv), b, 0, 0, -1);
        check_value("bad_cnt_err", err, 1);

        // zero count
        run_word(make_word(0, mv), b, 0, 0, -1);
        check_value("zero_done",  done, 1);
        check_value("zero_board", board_out, b);

        // pacing every 3rd cycle, with a start while replaying
        run_word(w, b, 1, 1, -1);
        check_value("pace_board", board_out, pack_cells(final_cells));

        // reset mid-replay, then fresh replay
        run_word(w, b, 0, 0, 2);
        check_value("rst_board", board_out, 0);
        check_value("rst_busy",  busy, 0);
        run_word(w, b, 0, 0, -1);
        check_value("replay_board", board_out, pack_cells(final_cells));

        // randomized scenarios
        for (int n = 0; n < 150; n++) begin
            int cnt, pos, t, d, j, tmp, mode;
            for (int k = 0; k < 9; k++) cells[k] = k + 1;
            for (int k = 8; k > 0; k--) begin
                j = $urandom_range(0, k);
                tmp = cells[k]; cells[k] = cells[j]; cells[j] = tmp;
            end
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < 9; k++) if (cells[k] == 5) cells[k] = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                cells[$urandom_range(0, 8)] = 5;
            end
            cnt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 20));
            for (int i = 0; i < 20; i++) mv[i] = int'($urandom_range(0, 3));
            pos = -1;
            for (int k = 0; k < 9; k++) if (cells[k] == 5 && pos < 0) pos = k;
            if (pos >= 0 && $urandom_range(0, 9) < 7) begin
                for (int i = 0; i < cnt && i < 20; i++) begin
                    d = int'($urandom_range(0, 3));
                    while (!move_ok(pos, d, t)) d = (d + 1) % 4;
                    mv[i] = d;
                    pos = t;
                end
            end
            mode = int'($urandom_range(0, 2));
            run_word(make_word(cnt, mv), pack_cells(cells), mode,
                     ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1);
            if ($urandom_range(0, 3) == 0) cycle(0, 0, '0, '0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
